rgb2gray_arbiter: RTL and testbench

Round-robin arbiter sharing one `rgb2gray` converter between `num_req_p` independent pixel requesters. Grants one requester per accepted transfer and forwards its RGB triple to the converter. Records the grant index in an in-order tag FIFO and steers each returning gray result back to the originating requester. Sits between the per-channel pixel sources and the single converter instance in the image pipeline; no pixel is ever dropped or reordered within a requester.

---
 rtl/rgb2gray_arbiter_if.sv | 54 +++++
 rtl/rgb2gray_arbiter.sv | 143 ++++++++++++++
 tb/tb_rgb2gray_arbiter.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rgb2gray_arbiter_if.sv
// Handshake bundle between the per-requester pixel sources, the shared rgb2gray
// converter and the arbiter that multiplexes them.
interface rgb2gray_arbiter_if #(
    parameter int width_p   = 8,
    parameter int num_req_p = 4
);
    logic [num_req_p-1:0]         req_valid_i;
    logic [num_req_p*width_p-1:0] req_red_i;
    logic [num_req_p*width_p-1:0] req_green_i;
    logic [num_req_p*width_p-1:0] req_blue_i;
    logic [num_req_p-1:0]         req_ready_o;

    logic                         conv_valid_o;
    logic [width_p-1:0]           conv_red_o;
    logic [width_p-1:0]           conv_green_o;
    logic [width_p-1:0]           conv_blue_o;
    logic                         conv_ready_i;

    logic                         conv_valid_i;
    logic [width_p-1:0]           conv_gray_i;
    logic                         conv_ready_o;

    logic [num_req_p-1:0]         resp_valid_o;
    logic [width_p-1:0]           resp_gray_o;
    logic [num_req_p-1:0]         resp_ready_i;

    logic                         err_o;

    // arbiter side
    modport slave (
        input  req_valid_i, req_red_i, req_green_i, req_blue_i,
        output req_ready_o,
        output conv_valid_o, conv_red_o, conv_green_o, conv_blue_o,
        input  conv_ready_i,
        input  conv_valid_i, conv_gray_i,
        output conv_ready_o,
        output resp_valid_o, resp_gray_o,
        input  resp_ready_i,
        output err_o
    );

    // requesters plus converter side
    modport master (
        output req_valid_i, req_red_i, req_green_i, req_blue_i,
        input  req_ready_o,
        input  conv_valid_o, conv_red_o, conv_green_o, conv_blue_o,
        output conv_ready_i,
        output conv_valid_i, conv_gray_i,
        input  conv_ready_o,
        input  resp_valid_o, resp_gray_o,
        output resp_ready_i,
        input  err_o
    );
endinterface

// File: rtl/rgb2gray_arbiter.sv
// Round-robin sharing of one rgb2gray converter among num_req_p pixel requesters;
// an in-order tag FIFO routes each gray result back to the requester that issued it.
module rgb2gray_arbiter #(
    parameter int width_p     = 8,
    parameter int num_req_p   = 4,
    parameter int tag_depth_p = 4
) (
    input logic               clk_i,
    input logic               reset_ni,
    rgb2gray_arbiter_if.slave bus
);
    localparam int idx_w  = $clog2(num_req_p);
    localparam int fifo_w = $clog2(tag_depth_p);

    localparam logic [idx_w:0]   num_req_l = (idx_w+1)'(num_req_p);
    localparam logic [idx_w-1:0] last_req  = idx_w'(num_req_p - 1);
    localparam logic [fifo_w:0]  depth_l   = (fifo_w+1)'(tag_depth_p);

    logic [idx_w-1:0]   ptr;
    logic [idx_w-1:0]   grant;
    logic [idx_w:0]     cand;
    logic               any_valid;

    logic [idx_w-1:0]   tag_mem [tag_depth_p];
    logic [fifo_w-1:0]  wr_ptr;
    logic [fifo_w-1:0]  rd_ptr;
    logic [fifo_w:0]    count;
    logic [idx_w-1:0]   head;
    logic               fifo_full;
    logic               fifo_empty;

    logic               issue_ok;
    logic               conv_valid;
    logic               conv_ready;
    logic               issue;
    logic               pop;
    logic               err;

    logic [num_req_p-1:0] req_ready;
    logic [num_req_p-1:0] resp_valid;
    logic [width_p-1:0]   red;
    logic [width_p-1:0]   green;
    logic [width_p-1:0]   blue;

    // first valid requester at or after ptr, wrapping modulo num_req_p
    always_comb begin
        grant     = ptr;
        any_valid = 1'b0;
        cand      = '0;
        for (int i = 0; i < num_req_p; i++) begin
            cand = {1'b0, ptr} + (idx_w+1)'(i);
            if (cand >= num_req_l) begin
                cand = cand - num_req_l;
            end
            if (!any_valid && bus.req_valid_i[cand[idx_w-1:0]]) begin
                grant     = cand[idx_w-1:0];
                any_valid = 1'b1;
            end
        end
    end

    assign fifo_full  = (count == depth_l);
    assign fifo_empty = (count == '0);
    assign head       = tag_mem[rd_ptr];

    // a full FIFO blocks issue even when a pop lands in the same cycle, which
    // keeps conv_ready_i out of the resp_ready_i path
    assign issue_ok   = !fifo_full;
    assign conv_valid = reset_ni & any_valid & issue_ok;
    assign issue      = conv_valid & bus.conv_ready_i;

    always_comb begin
        req_ready = '0;
        if (reset_ni && issue_ok && bus.conv_ready_i) begin
            req_ready[grant] = 1'b1;
        end
    end

    always_comb begin
        red   = '0;
        green = '0;
        blue  = '0;
        if (any_valid) begin
            red   = bus.req_red_i  [int'(grant)*width_p +: width_p];
            green = bus.req_green_i[int'(grant)*width_p +: width_p];
            blue  = bus.req_blue_i [int'(grant)*width_p +: width_p];
        end
    end

    always_comb begin
        resp_valid = '0;
        conv_ready = 1'b0;
        if (reset_ni && !fifo_empty) begin
            resp_valid[head] = bus.conv_valid_i;
            conv_ready       = bus.resp_ready_i[head];
        end
    end

    assign pop = bus.conv_valid_i & conv_ready;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            ptr    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err    <= 1'b0;
        end else begin
            if (issue) begin
                wr_ptr <= wr_ptr + 1'b1;
                ptr    <= (grant == last_req) ? '0 : grant + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (issue && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !issue) begin
                count <= count - 1'b1;
            end
            if (bus.conv_valid_i && fifo_empty) begin
                err <= 1'b1;
            end
        end
    end

    // tag storage needs no reset: entries are only read between push and pop
    always_ff @(posedge clk_i) begin
        if (issue) begin
            tag_mem[wr_ptr] <= grant;
        end
    end

    assign bus.req_ready_o  = req_ready;
    assign bus.conv_valid_o = conv_valid;
    assign bus.conv_red_o   = red;
    assign bus.conv_green_o = green;
    assign bus.conv_blue_o  = blue;
    assign bus.conv_ready_o = conv_ready;
    assign bus.resp_valid_o = resp_valid;
    assign bus.resp_gray_o  = bus.conv_gray_i;
    assign bus.err_o        = err;
endmodule

// File: tb/tb_rgb2gray_arbiter.sv
// Bench for rgb2gray_arbiter: queued requesters, a one-cycle converter model and a
// per-requester scoreboard of hand-computed gray values.
module tb_rgb2gray_arbiter;
    localparam int W = 8;
    localparam int N = 4;
    localparam int D = 4;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [7:0] gray;
    } pix_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    rgb2gray_arbiter_if #(.width_p(W), .num_req_p(N)) bus ();

    rgb2gray_arbiter #(.width_p(W), .num_req_p(N), .tag_depth_p(D)) dut (
        .clk_i   (clk),
        .reset_ni(reset_n),
        .bus     (bus)
    );

    pix_t       rq    [N][$];
    logic [7:0] exp_q [N][$];
    int         grant_log[$];
    logic [7:0] conv_q[$];
    logic       cq_valid = 1'b0;
    logic [7:0] cq_gray  = '0;
    logic       spur     = 1'b0;
    int         checks   = 0;
    int         errors   = 0;

    assign bus.conv_valid_i = cq_valid | spur;
    assign bus.conv_gray_i  = spur ? 8'h55 : cq_gray;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic send(input int k, input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b, input logic [7:0] gray);
        rq[k].push_back('{r: r, g: g, b: b, gray: gray});
        exp_q[k].push_back(gray);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic int pending();
        int n = 0;
        for (int k = 0; k < N; k++) n += exp_q[k].size();
        return n;
    endfunction

    task automatic drain();
        int n = 0;
        while (pending() != 0 && n < 200) begin
            step();
            n++;
        end
        if (pending() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses still outstanding", pending());
        end
    endtask

    // requesters, converter model and response monitor
    initial begin : env
        logic          iss;
        logic          ret;
        logic [N-1:0]  acc;
        logic [7:0]    g;
        int            h;
        bus.req_valid_i = '0;
        bus.req_red_i   = '0;
        bus.req_green_i = '0;
        bus.req_blue_i  = '0;
        forever begin
            @(negedge clk);
            #3;
            iss = bus.conv_valid_o & bus.conv_ready_i;
            acc = bus.req_ready_o & bus.req_valid_i;
            ret = bus.conv_valid_i & bus.conv_ready_o;
            g   = 8'((77 * int'(bus.conv_red_o) + 150 * int'(bus.conv_green_o)
                     + 29 * int'(bus.conv_blue_o)) >> 8);
            if (iss) begin
                check("issue_onehot", $countones(acc), 1);
                for (int k = 0; k < N; k++) if (acc[k]) grant_log.push_back(k);
            end
            if (ret) begin
                h = 0;
                for (int k = 0; k < N; k++) if (bus.resp_valid_o[k]) h = k;
                check("resp_onehot", $countones(bus.resp_valid_o), 1);
                if (exp_q[h].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_unexpected: requester %0d got %0h with none expected",
                             h, bus.resp_gray_o);
                end else begin
                    check($sformatf("resp_gray_req%0d", h), bus.resp_gray_o, exp_q[h].pop_front());
                end
            end
            @(posedge clk);
            #1;
            if (!reset_n) begin
                conv_q.delete();
            end else begin
                if (ret && conv_q.size() > 0) void'(conv_q.pop_front());
                if (iss) conv_q.push_back(g);
                for (int k = 0; k < N; k++) if (acc[k] && rq[k].size() > 0) void'(rq[k].pop_front());
            end
            cq_valid = (conv_q.size() > 0);
            cq_gray  = cq_valid ? conv_q[0] : 8'h00;
            for (int k = 0; k < N; k++) begin
                bus.req_valid_i[k] = (rq[k].size() > 0);
                if (rq[k].size() > 0) begin
                    bus.req_red_i  [k*W +: W] = rq[k][0].r;
                    bus.req_green_i[k*W +: W] = rq[k][0].g;
                    bus.req_blue_i [k*W +: W] = rq[k][0].b;
                end
            end
        end
    end

    initial begin : main
        int exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        bus.resp_ready_i = '1;
        bus.conv_ready_i = 1'b1;

        step();
        check("rst_req_ready", bus.req_ready_o, 0);
        check("rst_conv_valid", bus.conv_valid_o, 0);
        check("rst_resp_valid", bus.resp_valid_o, 0);
        check("rst_conv_ready", bus.conv_ready_o, 0);
        check("rst_err", bus.err_o, 0);
        step();
        reset_n = 1'b1;

        // fairness: all requesters busy, one issue per cycle in rotation
        step();
        grant_log.delete();
        send(0, 255, 255, 255, 255); send(0,   0,   0,   0,   0);
        send(1, 255,   0,   0,  76); send(1, 100, 100, 100, 100);
        send(2,   0, 255,   0, 149); send(2,   0,   0,   0,   0);
        send(3,   0,   0, 255,  28); send(3, 200, 200, 200, 200);
        repeat (8) step();
        @(negedge clk);
        #4;
        check("fair_issue_count", grant_log.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < grant_log.size()) check($sformatf("fair_grant%0d", i), grant_log[i], exp_order[i]);
        end
        drain();

        // single requester, zero-latency accept and one-cycle return
        step();
        send(2, 100, 100, 100, 100);
        step();
        check("single_req_ready", bus.req_ready_o, 4'b0100);
        check("single_conv_red", bus.conv_red_o, 100);
        step();
        check("single_resp_valid", bus.resp_valid_o, 4'b0100);
        check("single_resp_gray", bus.resp_gray_o, 100);
        check("single_err", bus.err_o, 0);
        drain();

        // return backpressure fills the tag FIFO
        step();
        grant_log.delete();
        bus.resp_ready_i = 4'b1101;
        send(1, 11, 11, 11, 11); send(1, 22, 22, 22, 22); send(1, 33, 33, 33, 33);
        send(1, 44, 44, 44, 44); send(1, 55, 55, 55, 55);
        repeat (6) step();
        check("bp_issued", grant_log.size(), 4);
        check("bp_req_ready", bus.req_ready_o, 0);
        check("bp_conv_valid", bus.conv_valid_o, 0);
        check("bp_resp_valid", bus.resp_valid_o, 4'b0010);
        check("bp_conv_ready", bus.conv_ready_o, 0);
        bus.resp_ready_i = '1;
        #1;
        check("bp_pop_ready", bus.conv_ready_o, 1);
        check("bp_full_blocks", bus.req_ready_o, 0);
        drain();

        // converter stall holds requester 3
        step();
        bus.conv_ready_i = 1'b0;
        send(3, 7, 7, 7, 7);
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_req_ready", bus.req_ready_o, 0);
            check("stall_conv_valid", bus.conv_valid_o, 1);
            check("stall_conv_blue", bus.conv_blue_o, 7);
        end
        bus.conv_ready_i = 1'b1;
        #1;
        check("stall_release", bus.req_ready_o, 4'b1000);
        drain();

        // result with no outstanding tag
        step();
        spur = 1'b1;
        #1;
        check("perr_resp_valid", bus.resp_valid_o, 0);
        check("perr_conv_ready", bus.conv_ready_o, 0);
        check("perr_err_before", bus.err_o, 0);
        step();
        check("perr_err_set", bus.err_o, 1);
        spur = 1'b0;
        repeat (3) step();
        check("perr_err_sticky", bus.err_o, 1);
        check("perr_resp_idle", bus.resp_valid_o, 0);
        reset_n = 1'b0;
        #1;
        check("perr_err_cleared", bus.err_o, 0);
        step();
        step();
        reset_n = 1'b1;

        // reset with three tags outstanding and a request pending
        step();
        bus.resp_ready_i = '0;
        send(1, 30, 30, 30, 30); send(1, 40, 40, 40, 40);
        send(2, 50, 50, 50, 50);
        repeat (4) step();
        bus.conv_ready_i = 1'b0;
        send(3, 60, 60, 60, 60);
        step();
        check("mid_conv_valid", bus.conv_valid_o, 1);
        check("mid_resp_valid", bus.resp_valid_o, 4'b0010);
        bus.resp_ready_i = '1;
        #1;
        check("mid_conv_ready", bus.conv_ready_o, 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_req_ready", bus.req_ready_o, 0);
        check("mid_rst_conv_valid", bus.conv_valid_o, 0);
        check("mid_rst_resp_valid", bus.resp_valid_o, 0);
        check("mid_rst_conv_ready", bus.conv_ready_o, 0);
        for (int k = 0; k < N; k++) begin
            rq[k].delete();
            exp_q[k].delete();
        end
        step();
        step();
        reset_n = 1'b1;
        bus.conv_ready_i = 1'b1;
        send(2, 80, 80, 80, 80);
        send(0, 90, 90, 90, 90);
        step();
        check("post_rst_grant0", bus.req_ready_o, 4'b0001);
        check("post_rst_conv_red", bus.conv_red_o, 90);
        check("post_rst_conv_ready", bus.conv_ready_o, 0);
        drain();
        check("post_rst_err", bus.err_o, 0);
        check("final_outstanding", pending(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
